// File: rtl/exe_dispatcher_if.sv
// exe_dispatcher_if -- bundle between the dispatcher, the IF/ID stage and the
// ALU/LSU execution pipes.
//
// Handshake semantics (apply to every valid/ready pair in this bundle):
//   A transfer ("fire") happens on a rising clock edge where valid and ready
//   are both high. While valid is high and ready is low, the producer keeps
//   valid and its payload stable. Ready may depend combinationally on
//   anything, but valid never depends on ready of the same cycle.
//   The IF/ID side uses the inverse form: id_exe_pipe != 0 offers an
//   instruction, and stall=1 means it was not taken and must be held.
//
// Signal groups:
//   decode   : flush, id_exe_pipe, id_a1, id_a2, id_rd, id_register_write, stall
//   issue    : alu_issue_valid/alu_ready, lsu_issue_valid/lsu_ready, issue_a1/a2/rd
//   writeback: wb_alu_valid/wb_alu_rd, wb_lsu_valid/wb_lsu_rd
//   status   : busy_regs, stall_cycles, dbg_alu_inflight, dbg_lsu_inflight
interface exe_dispatcher_if #(
    parameter int NUM_EXE_PIPES = 2,
    parameter int REG_WIDTH     = 5,
    parameter int DBG_CNT_W     = 8
);
    logic                     flush;
    logic [NUM_EXE_PIPES-1:0] id_exe_pipe;
    logic [REG_WIDTH-1:0]     id_a1;
    logic [REG_WIDTH-1:0]     id_a2;
    logic [REG_WIDTH-1:0]     id_rd;
    logic                     id_register_write;
    logic                     stall;

    logic                     alu_issue_valid;
    logic                     alu_ready;
    logic                     lsu_issue_valid;
    logic                     lsu_ready;
    logic [REG_WIDTH-1:0]     issue_a1;
    logic [REG_WIDTH-1:0]     issue_a2;
    logic [REG_WIDTH-1:0]     issue_rd;

    logic                     wb_alu_valid;
    logic [REG_WIDTH-1:0]     wb_alu_rd;
    logic                     wb_lsu_valid;
    logic [REG_WIDTH-1:0]     wb_lsu_rd;

    logic [31:0]              busy_regs;
    logic [31:0]              stall_cycles;
    logic [DBG_CNT_W-1:0]     dbg_alu_inflight;
    logic [DBG_CNT_W-1:0]     dbg_lsu_inflight;

    // Environment side: decode stage, execution pipes, writeback.
    modport master (
        output flush, id_exe_pipe, id_a1, id_a2, id_rd, id_register_write,
        output alu_ready, lsu_ready,
        output wb_alu_valid, wb_alu_rd, wb_lsu_valid, wb_lsu_rd,
        input  stall, alu_issue_valid, lsu_issue_valid,
        input  issue_a1, issue_a2, issue_rd,
        input  busy_regs, stall_cycles, dbg_alu_inflight, dbg_lsu_inflight
    );

    // Dispatcher side.
    modport slave (
        input  flush, id_exe_pipe, id_a1, id_a2, id_rd, id_register_write,
        input  alu_ready, lsu_ready,
        input  wb_alu_valid, wb_alu_rd, wb_lsu_valid, wb_lsu_rd,
        output stall, alu_issue_valid, lsu_issue_valid,
        output issue_a1, issue_a2, issue_rd,
        output busy_regs, stall_cycles, dbg_alu_inflight, dbg_lsu_inflight
    );
endinterface

// File: rtl/exe_dispatcher.sv
// exe_dispatcher -- holds one decoded instruction in an issue register and
// offers it to the ALU or LSU pipe. A 32-entry scoreboard blocks RAW/WAW
// hazards, and per-pipe in-flight counters cap outstanding work. IF/ID is held
// through the combinational stall output until the instruction is accepted.
//
// Ports:
//   clk  - core clock
//   rst  - synchronous, active-high reset
//   bus  - exe_dispatcher_if.slave (decode, issue, writeback and status signals)
module exe_dispatcher #(
    parameter int NUM_EXE_PIPES    = 2,
    parameter int EXE_PIPE_ALU_BIT = 0,
    parameter int EXE_PIPE_LSU_BIT = 1,
    parameter int ALU_CREDITS      = 2,
    parameter int LSU_CREDITS      = 4,
    parameter int REG_WIDTH        = 5,
    parameter int DBG_CNT_W        = 8
) (
    input logic              clk,
    input logic              rst,
    exe_dispatcher_if.slave  bus
);
    localparam int ACW = $clog2(ALU_CREDITS + 1);
    localparam int LCW = $clog2(LSU_CREDITS + 1);
    localparam logic [ACW-1:0] ALU_MAX = ACW'(ALU_CREDITS);
    localparam logic [LCW-1:0] LSU_MAX = LCW'(LSU_CREDITS);

    // Issue register
    logic                 alu_v_q, alu_v_d;
    logic                 lsu_v_q, lsu_v_d;
    logic [REG_WIDTH-1:0] a1_q, a1_d;
    logic [REG_WIDTH-1:0] a2_q, a2_d;
    logic [REG_WIDTH-1:0] rd_q, rd_d;
    // Scoreboard, in-flight counters, stall statistics
    logic [31:0]          busy_q, busy_d;
    logic [ACW-1:0]       alu_cnt_q, alu_cnt_d;
    logic [LCW-1:0]       lsu_cnt_q, lsu_cnt_d;
    logic [31:0]          stall_cnt_q, stall_cnt_d;

    logic id_valid, to_alu, to_lsu, hazard, credit_ok;
    logic held_valid, fire, slot_free, accept, stall, kill;
    int   alu_n, lsu_n;

    always_comb begin
        id_valid   = |bus.id_exe_pipe;
        to_alu     = bus.id_exe_pipe[EXE_PIPE_ALU_BIT];
        to_lsu     = bus.id_exe_pipe[EXE_PIPE_LSU_BIT];
        // Only registered scoreboard state is consulted: a writeback in this
        // cycle unblocks the waiting instruction one cycle later.
        hazard     = (bus.id_a1 != '0 && busy_q[bus.id_a1]) ||
                     (bus.id_a2 != '0 && busy_q[bus.id_a2]) ||
                     (bus.id_register_write && bus.id_rd != '0 && busy_q[bus.id_rd]);
        credit_ok  = (to_alu && alu_cnt_q < ALU_MAX) || (to_lsu && lsu_cnt_q < LSU_MAX);
        held_valid = alu_v_q || lsu_v_q;
        fire       = (alu_v_q && bus.alu_ready) || (lsu_v_q && bus.lsu_ready);
        slot_free  = !held_valid || fire;
        accept     = id_valid && !bus.flush && !hazard && credit_ok && slot_free;
        stall      = id_valid && !accept;
        // A held instruction that fires during flush counts as issued; only
        // one that is still waiting gets squashed.
        kill       = bus.flush && held_valid && !fire;
    end

    always_comb begin
        alu_v_d     = alu_v_q;
        lsu_v_d     = lsu_v_q;
        a1_d        = a1_q;
        a2_d        = a2_q;
        rd_d        = rd_q;
        busy_d      = busy_q;
        stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;

        if (accept) begin
            alu_v_d = to_alu;
            lsu_v_d = to_lsu;
            a1_d    = bus.id_a1;
            a2_d    = bus.id_a2;
            rd_d    = bus.id_register_write ? bus.id_rd : '0;
        end else if (fire || kill) begin
            alu_v_d = 1'b0;
            lsu_v_d = 1'b0;
        end

        // Clears first, then the set: a set and clear of the same register
        // cannot coincide because WAW blocks the issue.
        if (bus.wb_alu_valid && bus.wb_alu_rd != '0) busy_d[bus.wb_alu_rd] = 1'b0;
        if (bus.wb_lsu_valid && bus.wb_lsu_rd != '0) busy_d[bus.wb_lsu_rd] = 1'b0;
        if (kill && rd_q != '0)                      busy_d[rd_q]          = 1'b0;
        if (accept && bus.id_register_write && bus.id_rd != '0) busy_d[bus.id_rd] = 1'b1;
        busy_d[0] = 1'b0;

        // Up to one increment and two decrements (writeback + squash) per
        // pipe; the result floors at zero so a stray writeback cannot wrap.
        alu_n = int'(alu_cnt_q) + int'(accept && to_alu)
                - int'(bus.wb_alu_valid) - int'(kill && alu_v_q);
        lsu_n = int'(lsu_cnt_q) + int'(accept && to_lsu)
                - int'(bus.wb_lsu_valid) - int'(kill && lsu_v_q);
        if (alu_n < 0) alu_n = 0;
        if (lsu_n < 0) lsu_n = 0;
        alu_cnt_d = ACW'(alu_n);
        lsu_cnt_d = LCW'(lsu_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_v_q     <= 1'b0;
            lsu_v_q     <= 1'b0;
            a1_q        <= '0;
            a2_q        <= '0;
            rd_q        <= '0;
            busy_q      <= '0;
            alu_cnt_q   <= '0;
            lsu_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            alu_v_q     <= alu_v_d;
            lsu_v_q     <= lsu_v_d;
            a1_q        <= a1_d;
            a2_q        <= a2_d;
            rd_q        <= rd_d;
            busy_q      <= busy_d;
            alu_cnt_q   <= alu_cnt_d;
            lsu_cnt_q   <= lsu_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall            = stall;
    assign bus.alu_issue_valid  = alu_v_q;
    assign bus.lsu_issue_valid  = lsu_v_q;
    assign bus.issue_a1         = a1_q;
    assign bus.issue_a2         = a2_q;
    assign bus.issue_rd         = rd_q;
    assign bus.busy_regs        = busy_q;
    assign bus.stall_cycles     = stall_cnt_q;
    assign bus.dbg_alu_inflight = DBG_CNT_W'(alu_cnt_q);
    assign bus.dbg_lsu_inflight = DBG_CNT_W'(lsu_cnt_q);

    a_pipe_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.id_exe_pipe));
    a_no_set_clear_same_rd: assert property (@(posedge clk) disable iff (rst)
        !(accept && bus.id_register_write && bus.id_rd != '0 &&
          ((bus.wb_alu_valid && bus.wb_alu_rd == bus.id_rd) ||
           (bus.wb_lsu_valid && bus.wb_lsu_rd == bus.id_rd))));
    a_alu_wb_nonzero: assert property (@(posedge clk) disable iff (rst)
        !(bus.wb_alu_valid && alu_cnt_q == '0));
    a_lsu_wb_nonzero: assert property (@(posedge clk) disable iff (rst)
        !(bus.wb_lsu_valid && lsu_cnt_q == '0));
endmodule

// File: tb/tb_exe_dispatcher.sv
module tb_exe_dispatcher;
    localparam int ALU_CREDITS = 2;
    localparam int LSU_CREDITS = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exe_dispatcher_if #(.NUM_EXE_PIPES(2), .REG_WIDTH(5), .DBG_CNT_W(8)) bus ();

    exe_dispatcher #(
        .NUM_EXE_PIPES(2), .EXE_PIPE_ALU_BIT(0), .EXE_PIPE_LSU_BIT(1),
        .ALU_CREDITS(ALU_CREDITS), .LSU_CREDITS(LSU_CREDITS),
        .REG_WIDTH(5), .DBG_CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Held instruction plus per-pipe queues of issued-but-not-written-back
    // destinations. In-flight count = queue length + held instruction of that pipe.
    bit          m_v;
    int          m_pipe;            // 0 = ALU, 1 = LSU
    logic [4:0]  m_a1, m_a2, m_rd;
    logic [31:0] m_busy;
    logic [4:0]  alu_pend[$];
    logic [4:0]  lsu_pend[$];
    int          m_stalls;
    logic        obs_stall;

    function automatic int inflight(input int p);
        int n;
        n = (p == 0) ? alu_pend.size() : lsu_pend.size();
        if (m_v && m_pipe == p) n++;
        return n;
    endfunction

    task automatic compare_regs();
        check("alu_issue_valid", bus.alu_issue_valid, m_v && m_pipe == 0);
        check("lsu_issue_valid", bus.lsu_issue_valid, m_v && m_pipe == 1);
        if (m_v) begin
            check("issue_a1", bus.issue_a1, m_a1);
            check("issue_a2", bus.issue_a2, m_a2);
            check("issue_rd", bus.issue_rd, m_rd);
        end
        check("busy_regs", bus.busy_regs, m_busy);
        check("stall_cycles", bus.stall_cycles, m_stalls);
        check("alu_inflight", bus.dbg_alu_inflight, inflight(0));
        check("lsu_inflight", bus.dbg_lsu_inflight, inflight(1));
    endtask

    // Inputs are already driven (after a negedge). Check stall, advance the
    // model across the posedge, then check registered outputs.
    task automatic step();
        bit idv, haz, cred, fire, acc, exp_stall;
        int p, lim;
        logic [4:0] r;
        #1;
        idv  = bus.id_exe_pipe != 2'b00;
        p    = bus.id_exe_pipe[1] ? 1 : 0;
        haz  = (bus.id_a1 != 0 && m_busy[bus.id_a1]) ||
               (bus.id_a2 != 0 && m_busy[bus.id_a2]) ||
               (bus.id_register_write && bus.id_rd != 0 && m_busy[bus.id_rd]);
        lim  = (p == 0) ? ALU_CREDITS : LSU_CREDITS;
        cred = inflight(p) < lim;
        fire = m_v && ((m_pipe == 0) ? bus.alu_ready : bus.lsu_ready);
        acc  = idv && !bus.flush && !haz && cred && (!m_v || fire);
        exp_stall = idv && !acc;
        obs_stall = bus.stall;
        check("stall", bus.stall, exp_stall);

        if (exp_stall) m_stalls++;
        if (bus.wb_alu_valid) begin
            r = alu_pend.pop_front();
            if (r != 0) m_busy[r] = 1'b0;
        end
        if (bus.wb_lsu_valid) begin
            r = lsu_pend.pop_front();
            if (r != 0) m_busy[r] = 1'b0;
        end
        if (fire) begin
            if (m_pipe == 0) alu_pend.push_back(m_rd);
            else             lsu_pend.push_back(m_rd);
            m_v = 1'b0;
        end else if (m_v && bus.flush) begin
            if (m_rd != 0) m_busy[m_rd] = 1'b0;
            m_v = 1'b0;
        end
        if (acc) begin
            m_v    = 1'b1;
            m_pipe = p;
            m_a1   = bus.id_a1;
            m_a2   = bus.id_a2;
            m_rd   = bus.id_register_write ? bus.id_rd : 5'd0;
            if (m_rd != 0) m_busy[m_rd] = 1'b1;
        end

        @(posedge clk);
        @(negedge clk);
        compare_regs();
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        bus.flush             = 1'b0;
        bus.id_exe_pipe       = 2'b00;
        bus.id_a1             = '0;
        bus.id_a2             = '0;
        bus.id_rd             = '0;
        bus.id_register_write = 1'b0;
        bus.wb_alu_valid      = 1'b0;
        bus.wb_alu_rd         = '0;
        bus.wb_lsu_valid      = 1'b0;
        bus.wb_lsu_rd         = '0;
    endtask

    task automatic drive_id(input int p, input int a1, input int a2, input int rd, input bit w);
        bus.id_exe_pipe       = (p == 0) ? 2'b01 : 2'b10;
        bus.id_a1             = 5'(a1);
        bus.id_a2             = 5'(a2);
        bus.id_rd             = 5'(rd);
        bus.id_register_write = w;
    endtask

    // Writebacks always return the oldest issued instruction of the pipe.
    task automatic drive_wb(input bit alu, input bit lsu);
        bus.wb_alu_valid = alu && alu_pend.size() > 0;
        bus.wb_alu_rd    = (alu_pend.size() > 0) ? alu_pend[0] : 5'd0;
        bus.wb_lsu_valid = lsu && lsu_pend.size() > 0;
        bus.wb_lsu_rd    = (lsu_pend.size() > 0) ? lsu_pend[0] : 5'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_idle();
        // Reset must win over a concurrent flush and offered instruction.
        bus.flush = 1'b1;
        drive_id(0, 1, 2, 3, 1'b1);
        bus.alu_ready = 1'b1;
        bus.lsu_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        set_idle();
        m_v = 1'b0; m_pipe = 0; m_a1 = '0; m_a2 = '0; m_rd = '0;
        m_busy = '0; alu_pend.delete(); lsu_pend.delete(); m_stalls = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        set_idle();
        bus.alu_ready = 1'b1;
        bus.lsu_ready = 1'b1;
        while ((m_v || alu_pend.size() > 0 || lsu_pend.size() > 0) && n < 64) begin
            drive_wb(1'b1, 1'b1);
            step();
            n++;
        end
        set_idle();
        if (n >= 64) check("drain_timeout", 32'd1, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        do_reset();
        @(negedge clk);
        check("rst_issue_a1", bus.issue_a1, 0);
        check("rst_issue_a2", bus.issue_a2, 0);
        check("rst_issue_rd", bus.issue_rd, 0);
        check("rst_stall", bus.stall, 0);
        compare_regs();

        // ALU add x5 <- x1, x2
        bus.alu_ready = 1'b1;
        drive_id(0, 1, 2, 5, 1'b1);
        step();
        check("add_stall", obs_stall, 0);
        check("add_valid", bus.alu_issue_valid, 1);
        check("add_rd", bus.issue_rd, 5);
        check("add_busy", bus.busy_regs, 32'h20);

        // Dependent on x5: stalls until the writeback of x5 has been registered
        drive_id(0, 5, 0, 6, 1'b1);
        repeat (3) begin
            step();
            check("raw_stall", obs_stall, 1);
        end
        drive_wb(1'b1, 1'b0);
        step();
        check("raw_stall_wb_cycle", obs_stall, 1);
        bus.wb_alu_valid = 1'b0;
        step();
        check("raw_accept", obs_stall, 0);
        check("raw_stall_count", bus.stall_cycles, 4);
        check("raw_busy", bus.busy_regs, 32'h40);
        drain();

        // LSU slot and credit limits
        bus.lsu_ready = 1'b0;
        drive_id(1, 0, 0, 1, 1'b1);
        step();
        drive_id(1, 0, 0, 2, 1'b1);
        step();
        check("lsu_slot_stall", obs_stall, 1);
        bus.lsu_ready = 1'b1;
        step();
        drive_id(1, 0, 0, 3, 1'b1);
        step();
        drive_id(1, 0, 0, 4, 1'b1);
        step();
        drive_id(1, 0, 0, 8, 1'b1);
        step();
        check("lsu_credit_stall", obs_stall, 1);
        check("lsu_inflight_full", bus.dbg_lsu_inflight, 4);
        step();
        drive_wb(1'b0, 1'b1);
        step();
        check("lsu_credit_wb_cycle", obs_stall, 1);
        bus.wb_lsu_valid = 1'b0;
        step();
        check("lsu_credit_accept", obs_stall, 0);
        drain();

        // Flush a held ALU instruction with rd=7
        bus.alu_ready = 1'b0;
        drive_id(0, 0, 0, 7, 1'b1);
        step();
        set_idle();
        bus.flush = 1'b1;
        step();
        check("flush_stall", obs_stall, 0);
        check("flush_valid", bus.alu_issue_valid, 0);
        check("flush_busy7", bus.busy_regs[7], 0);
        check("flush_alu_cnt", bus.dbg_alu_inflight, 0);
        bus.flush = 1'b0;
        drain();

        // Two writebacks plus a new ALU accept in the same cycle
        drive_id(0, 0, 0, 3, 1'b1);
        step();
        drive_id(1, 0, 0, 9, 1'b1);
        step();
        set_idle();
        step();
        check("dual_busy_before", bus.busy_regs, 32'h208);
        bus.alu_ready = 1'b0;
        drive_id(0, 0, 0, 4, 1'b1);
        drive_wb(1'b1, 1'b1);
        step();
        check("dual_accept", obs_stall, 0);
        check("dual_busy_after", bus.busy_regs, 32'h10);
        check("dual_alu_cnt", bus.dbg_alu_inflight, 1);
        check("dual_lsu_cnt", bus.dbg_lsu_inflight, 0);
        drain();

        // Store (no write) and load to x0
        drive_id(1, 1, 2, 0, 1'b0);
        step();
        drive_id(1, 3, 0, 0, 1'b1);
        step();
        set_idle();
        step();
        check("x0_busy", bus.busy_regs, 0);
        check("x0_lsu_cnt", bus.dbg_lsu_inflight, 2);
        drive_wb(1'b0, 1'b1);
        step();
        drive_wb(1'b0, 1'b1);
        step();
        check("x0_busy_after_wb", bus.busy_regs, 0);
        check("x0_lsu_cnt_after_wb", bus.dbg_lsu_inflight, 0);
        drain();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            int k;
            set_idle();
            k = $urandom_range(0, 3);
            if (k != 0)
                drive_id((k == 3) ? 1 : 0, $urandom_range(0, 7), $urandom_range(0, 7),
                         $urandom_range(0, 7), $urandom_range(0, 3) != 0);
            bus.alu_ready = $urandom_range(0, 3) != 0;
            bus.lsu_ready = $urandom_range(0, 3) != 0;
            bus.flush     = $urandom_range(0, 15) == 0;
            drive_wb($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            step();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
